// File: rtl/nibble_serial_subtractor_if.sv
// Handshake/result bundle for nibble_serial_subtractor.
// The ovf signal exists only when SUB_OVF_EN is defined.
interface nibble_serial_subtractor_if #(
  parameter int WIDTH = 16
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             borrow_in;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] d;
  logic             borrow_out;
  logic             zero;
`ifdef SUB_OVF_EN
  logic             ovf;

  modport master (output start, a, b, borrow_in,
                  input  busy, done, d, borrow_out, zero, ovf);
  modport slave  (input  start, a, b, borrow_in,
                  output busy, done, d, borrow_out, zero, ovf);
`else
  modport master (output start, a, b, borrow_in,
                  input  busy, done, d, borrow_out, zero);
  modport slave  (input  start, a, b, borrow_in,
                  output busy, done, d, borrow_out, zero);
`endif
endinterface

// File: rtl/nibble_serial_subtractor.sv
// Serial subtractor: d = a - b - borrow_in, one 4-bit lookahead slice per clock.
// Define SUB_OVF_EN to add the registered signed-overflow output ovf.
//
// state | meaning
// IDLE  | waiting for start; done pulses here for one cycle after completion
// RUN   | processing nibble idx, borrow carried in brw between nibbles
module nibble_serial_subtractor #(
  parameter int WIDTH = 16
) (
  input logic                       clk,
  input logic                       rst,
  nibble_serial_subtractor_if.slave bus
);
  localparam int NIB   = WIDTH / 4;
  localparam int IDX_W = (NIB > 1) ? $clog2(NIB) : 1;

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t           state;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] d_q;
  logic [IDX_W-1:0] idx;
  logic             brw;
  logic             busy_q;
  logic             done_q;
  logic             bout_q;
  logic             zero_q;

  logic [IDX_W+1:0] bit_off;
  logic [3:0]       a_nib;
  logic [3:0]       b_nib;
  logic [4:0]       sum5;
  logic [WIDTH-1:0] d_new;
  logic             last;

  assign bit_off = {idx, 2'b00};
  assign last    = (idx == IDX_W'(NIB - 1));

  // a - b - brw == a + ~b + ~brw; carry out of the slice is the inverted borrow
  always_comb begin
    a_nib = a_q[bit_off +: 4];
    b_nib = b_q[bit_off +: 4];
    sum5  = {1'b0, a_nib} + {1'b0, ~b_nib} + {4'b0000, ~brw};
    d_new = d_q;
    d_new[bit_off +: 4] = sum5[3:0];
  end

`ifdef SUB_OVF_EN
  logic ovf_q;
  assign bus.ovf = ovf_q;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      a_q    <= '0;
      b_q    <= '0;
      d_q    <= '0;
      idx    <= '0;
      brw    <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      bout_q <= 1'b0;
      zero_q <= 1'b0;
`ifdef SUB_OVF_EN
      ovf_q  <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          done_q <= 1'b0;
          if (bus.start) begin
            a_q    <= bus.a;
            b_q    <= bus.b;
            brw    <= bus.borrow_in;
            idx    <= '0;
            busy_q <= 1'b1;
            state  <= RUN;
          end
        end
        RUN: begin
          d_q <= d_new;
          brw <= ~sum5[4];
          idx <= idx + 1'b1;
          if (last) begin
            state  <= IDLE;
            busy_q <= 1'b0;
            done_q <= 1'b1;
            bout_q <= ~sum5[4];
            zero_q <= (d_new == '0);
`ifdef SUB_OVF_EN
            // signs of a and b differ and the result sign departs from a
            ovf_q  <= (a_q[WIDTH-1] ^ b_q[WIDTH-1]) & (d_new[WIDTH-1] ^ a_q[WIDTH-1]);
`endif
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.d          = d_q;
  assign bus.borrow_out = bout_q;
  assign bus.zero       = zero_q;
endmodule

// File: tb/tb_nibble_serial_subtractor.sv
// Scoreboard bench for nibble_serial_subtractor: driver pushes model results,
// a monitor pops and compares on every done pulse.
module tb_nibble_serial_subtractor;
  localparam int WIDTH = 16;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  nibble_serial_subtractor_if #(.WIDTH(WIDTH)) sif ();
  nibble_serial_subtractor #(.WIDTH(WIDTH)) dut (.clk(clk), .rst(rst), .bus(sif));

  typedef struct {
    logic [WIDTH-1:0] d;
    logic             bout;
    logic             zero;
    logic             ovf;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  function automatic void chk(string name, logic [63:0] act, logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endfunction

  // Plain integer arithmetic reference: unsigned and signed views of a - b - bin.
  function automatic exp_t model(logic [WIDTH-1:0] a, logic [WIDTH-1:0] b, logic bin);
    exp_t   e;
    longint span = longint'(1) << WIDTH;
    longint ud   = longint'(a) - longint'(b) - longint'(bin);
    longint sa   = longint'(a) - ((a >= WIDTH'(span / 2)) ? span : 0);
    longint sb   = longint'(b) - ((b >= WIDTH'(span / 2)) ? span : 0);
    longint sd   = sa - sb - longint'(bin);
    e.bout = (ud < 0);
    if (ud < 0) ud = ud + span;
    e.d    = WIDTH'(ud);
    e.zero = (ud == 0);
    e.ovf  = (sd >= span / 2) || (sd < -(span / 2));
    return e;
  endfunction

  logic prev_done = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      prev_done = 1'b0;
    end else begin
      if (sif.done) begin
        chk("done_pulse_width", prev_done, 0);
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_done: got done=1, expected no completion (d=0x%0h)", sif.d);
        end else begin
          e = exp_q.pop_front();
          chk("d", sif.d, e.d);
          chk("borrow_out", sif.borrow_out, e.bout);
          chk("zero", sif.zero, e.zero);
`ifdef SUB_OVF_EN
          chk("ovf", sif.ovf, e.ovf);
`endif
        end
      end
      prev_done = sif.done;
    end
  end

  // Called at a negedge with the DUT idle; returns at the negedge after the accepting edge.
  task automatic issue(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic bin);
    sif.a         = a;
    sif.b         = b;
    sif.borrow_in = bin;
    sif.start     = 1'b1;
    @(posedge clk);
    exp_q.push_back(model(a, b, bin));
    @(negedge clk);
    sif.start = 1'b0;
  endtask

  task automatic wait_done(output int cyc, output int bcnt);
    cyc  = 0;
    bcnt = sif.busy ? 1 : 0;
    while (!sif.done && cyc < 20) begin
      @(negedge clk);
      cyc++;
      if (sif.busy) bcnt++;
    end
    if (!sif.done) begin
      n_checks++;
      n_fail++;
      $display("FAIL done_timeout: got no done after %0d cycles, expected done", cyc);
    end
  endtask

  task automatic run_op(string name, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                        input logic bin);
    int cyc, bcnt;
    issue(a, b, bin);
    wait_done(cyc, bcnt);
    chk({name, "_latency"}, cyc, 4);
    chk({name, "_busy_cycles"}, bcnt, 4);
  endtask

  task automatic check_zero_outputs(string name);
    chk({name, "_busy"}, sif.busy, 0);
    chk({name, "_done"}, sif.done, 0);
    chk({name, "_d"}, sif.d, 0);
    chk({name, "_borrow_out"}, sif.borrow_out, 0);
    chk({name, "_zero"}, sif.zero, 0);
`ifdef SUB_OVF_EN
    chk({name, "_ovf"}, sif.ovf, 0);
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got simulation still running, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    int cyc, bcnt;
    sif.start     = 1'b0;
    sif.a         = '0;
    sif.b         = '0;
    sif.borrow_in = 1'b0;
    #2 rst = 1'b1;
    repeat (2) @(negedge clk);
    check_zero_outputs("reset");
    rst = 1'b0;
    repeat (2) @(negedge clk);

    run_op("t1", 16'h1234, 16'h0234, 1'b0);
    run_op("t2a", 16'h0000, 16'h0001, 1'b0);
    run_op("t2b", 16'h0005, 16'h0005, 1'b1);
    run_op("t3", 16'hABCD, 16'hABCD, 1'b0);

    // start during RUN is ignored; start in the done cycle is accepted
    issue(16'h0010, 16'h0001, 1'b0);
    @(negedge clk);
    sif.a     = 16'hFFFF;
    sif.b     = 16'h0001;
    sif.start = 1'b1;
    @(negedge clk);
    sif.start = 1'b0;
    wait_done(cyc, bcnt);
    chk("t4_latency", cyc, 2);
    run_op("t4_done_cycle", 16'h0100, 16'h0001, 1'b1);

    // abort mid-run: nibble 0 of d is already nonzero before reset hits
    issue(16'h5678, 16'h1111, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_zero_outputs("t5_abort");
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;
    repeat (8) @(negedge clk);
    run_op("t5_after", 16'h5678, 16'h1111, 1'b0);

    run_op("t6a", 16'h8000, 16'h0001, 1'b0);
    run_op("t6b", 16'h7FFF, 16'hFFFF, 1'b0);
    run_op("t6c", 16'h0003, 16'h0001, 1'b0);

    for (int i = 0; i < 40; i++) begin
      logic [WIDTH-1:0] ra, rb;
      ra = WIDTH'($urandom);
      rb = (i % 5 == 0) ? ra : WIDTH'($urandom);
      run_op("rand", ra, rb, 1'($urandom));
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    repeat (3) @(negedge clk);
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/nibble_serial_subtractor.md
Name: nibble_serial_subtractor

Overview:
- Multi-cycle subtractor: computes d = a − b − borrow_in over WIDTH bits, 4 bits per clock.
- Each nibble uses a 4-bit generate/propagate lookahead slice: a + ~b + ~borrow. The borrow is registered between nibbles.
- Inverse-operation companion to the team's 4-bit lookahead adder. Used where wide subtraction must be done with minimal logic and latency is acceptable.

Parameters:
- WIDTH, 16, operand and result width in bits. Must be a multiple of 4 and ≥ 4. NIB = WIDTH/4 is the cycle count.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- start  input  1  request; sampled only in IDLE
- a  input  WIDTH  minuend, latched on accepted start
- b  input  WIDTH  subtrahend, latched on accepted start
- borrow_in  input  1  borrow into bit 0, latched on accepted start
- busy  output  1  high while in RUN
- done  output  1  one-cycle pulse, result valid
- d  output  WIDTH  difference; holds until next completion
- borrow_out  output  1  borrow out of MSB (1 means a < b + borrow_in, unsigned)
- zero  output  1  d == 0, registered at completion

Behaviour:
- Reset: async, active-high. Asynchronously forces state IDLE and clears busy, done, d, borrow_out, zero, internal operand registers, nibble index and borrow register to 0.
- States: IDLE, RUN.
  - IDLE → RUN on rising edge with start = 1. That edge latches a, b, borrow_in, sets index = 0 and sets busy = 1.
  - RUN: at each edge, nibble k = index is computed:
    - sum5 = a[4k+3:4k] + ~b[4k+3:4k] + ~brw, where brw is the registered borrow.
    - Write d[4k+3:4k] = sum5[3:0].
    - brw ← ~sum5[4].
    - index ← index + 1.
  - RUN → IDLE at the edge processing nibble NIB−1. Same edge: borrow_out ← final borrow, zero ← (full new d == 0), done ← 1, busy ← 0.
- Latency: start edge E0; result and done visible after edge E(NIB). For WIDTH = 16, done is high exactly 4 cycles after start is sampled.
- done: high for exactly one cycle, then cleared by the next edge.
- start while busy: ignored. No queuing, operands unchanged.
- start in the same cycle done is high: accepted, since the state is IDLE.
- d is written nibble-by-nibble during RUN. It is valid only when done is high and in the hold period afterwards. borrow_out and zero update only at completion.
- Reset mid-RUN: operation aborted, no done pulse, all outputs 0.
- Arithmetic wraps modulo 2^WIDTH. No saturation.
- No combinational path from inputs to outputs.

Optional Feature:
- Macro SUB_OVF_EN.
- Defined: adds output port ovf (output, 1). It is the signed two's-complement overflow of a − b − borrow_in: the operand sign bits differ and the result sign differs from a's sign.
  - Registered at completion, with the same timing as borrow_out.
  - Reset to 0.
- Undefined: port and logic absent. Other behaviour is identical.

Test Plan:
1. WIDTH = 16, a = 0x1234, b = 0x0234, borrow_in = 0 → after 4 cycles: done pulse, d = 0x1000, borrow_out = 0, zero = 0, busy high for exactly 4 cycles.
2. a = 0x0000, b = 0x0001, borrow_in = 0 → d = 0xFFFF, borrow_out = 1. The borrow ripples through all 4 nibbles. The same check with a = 0x0005, b = 0x0005, borrow_in = 1 → d = 0xFFFF, borrow_out = 1.
3. a = 0xABCD, b = 0xABCD, borrow_in = 0 → d = 0x0000, zero = 1, borrow_out = 0.
4. Start 0x0010 − 0x0001, then pulse start with new operands at cycle 2 → ignored. Result d = 0x000F at cycle 4. Next start is accepted in the done cycle and completes 4 cycles later.
5. Assert rst at cycle 2 of RUN → busy, d, done immediately 0. No done pulse follows. A fresh start after reset completes normally.
6. SUB_OVF_EN defined: 0x8000 − 0x0001 → d = 0x7FFF, ovf = 1, borrow_out = 0. 0x7FFF − 0xFFFF → d = 0x8000, ovf = 1, borrow_out = 1. 0x0003 − 0x0001 → ovf = 0.
